operand_fetch: RTL and testbench

Operand-fetch stage sitting between instruction decode and the execute stage, directly in front of the 16 x 32-bit register file. It drives the register file's two read addresses, merges the read data with forwarded results from EX and writeback, and stalls on unresolved dependencies. It captures the resolved operands into a single-entry ID/EX pipeline register with a valid/ready handshake.

---
 rtl/operand_fetch_if.sv | 67 ++++++
 rtl/operand_fetch.sv | 134 +++++++++++++
 tb/tb_operand_fetch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Bundle between decode, register file, forwarding sources and the ID/EX
// register. The operand-fetch stage connects through the slave modport.
interface operand_fetch_if #(
  parameter int DATA_BITS    = 32,
  parameter int ADDRESS_BITS = 4,
  parameter int STALL_BITS   = 16
);
  // Decode side
  logic                    in_valid;
  logic                    in_ready;
  logic [ADDRESS_BITS-1:0] in_src1;
  logic [ADDRESS_BITS-1:0] in_src2;
  logic                    in_use1;
  logic                    in_use2;
  logic [ADDRESS_BITS-1:0] in_dst;
  logic                    in_wr;
  logic                    in_is_load;

  // Register file read port
  logic [ADDRESS_BITS-1:0] r_addr1;
  logic [ADDRESS_BITS-1:0] r_addr2;
  logic [DATA_BITS-1:0]    d_out1;
  logic [DATA_BITS-1:0]    d_out2;

  // Forwarding, pending load and writeback
  logic                    ex_fwd_en;
  logic [ADDRESS_BITS-1:0] ex_fwd_addr;
  logic [DATA_BITS-1:0]    ex_fwd_data;
  logic                    ex_ld_pend;
  logic [ADDRESS_BITS-1:0] ex_ld_addr;
  logic                    wb_wrt_en;
  logic [ADDRESS_BITS-1:0] wb_w_addr;
  logic [DATA_BITS-1:0]    wb_d_in;

  // ID/EX register side
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_BITS-1:0]    out_op1;
  logic [DATA_BITS-1:0]    out_op2;
  logic [ADDRESS_BITS-1:0] out_dst;
  logic                    out_wr;
  logic                    out_is_load;
  logic [STALL_BITS-1:0]   stall_cnt;

  modport slave (
    input  in_valid, in_src1, in_src2, in_use1, in_use2, in_dst, in_wr, in_is_load,
    output in_ready,
    output r_addr1, r_addr2,
    input  d_out1, d_out2,
    input  ex_fwd_en, ex_fwd_addr, ex_fwd_data, ex_ld_pend, ex_ld_addr,
    input  wb_wrt_en, wb_w_addr, wb_d_in,
    input  flush, out_ready,
    output out_valid, out_op1, out_op2, out_dst, out_wr, out_is_load, stall_cnt
  );

  modport master (
    output in_valid, in_src1, in_src2, in_use1, in_use2, in_dst, in_wr, in_is_load,
    input  in_ready,
    input  r_addr1, r_addr2,
    output d_out1, d_out2,
    output ex_fwd_en, ex_fwd_addr, ex_fwd_data, ex_ld_pend, ex_ld_addr,
    output wb_wrt_en, wb_w_addr, wb_d_in,
    output flush, out_ready,
    input  out_valid, out_op1, out_op2, out_dst, out_wr, out_is_load, stall_cnt
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, applies EX/WB forwarding, stalls on
// unresolved dependencies and holds one resolved instruction for EX.
module operand_fetch #(
  parameter int DATA_BITS    = 32,
  parameter int ADDRESS_BITS = 4,
  parameter int STALL_BITS   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_fetch_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [DATA_BITS-1:0]    op1_reg;
  logic [DATA_BITS-1:0]    op2_reg;
  logic [ADDRESS_BITS-1:0] dst_reg;
  logic                    wr_reg;
  logic                    is_load_reg;
  logic [STALL_BITS-1:0]   stall_reg;
  logic [STALL_BITS-1:0]   stall_next;

  logic [ADDRESS_BITS-1:0] src      [2];
  logic                    use_src  [2];
  logic [DATA_BITS-1:0]    rf_data  [2];
  logic [DATA_BITS-1:0]    resolved [2];
  logic [1:0]              hazard_src;

  logic out_valid;
  logic hazard;
  logic in_ready;
  logic accept;

  assign out_valid = (state_reg == FULL);

  assign src[0]     = bus.in_src1;
  assign src[1]     = bus.in_src2;
  assign use_src[0] = bus.in_use1;
  assign use_src[1] = bus.in_use2;
  assign rf_data[0] = bus.d_out1;
  assign rf_data[1] = bus.d_out2;

  // EX beats WB; WB is needed because the register file still returns the old
  // value during its write cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign resolved[gi] =
        (bus.ex_fwd_en && (bus.ex_fwd_addr == src[gi])) ? bus.ex_fwd_data :
        (bus.wb_wrt_en && (bus.wb_w_addr  == src[gi])) ? bus.wb_d_in     :
                                                          rf_data[gi];

      // A producer still sitting in ID/EX has no result yet, even if it is
      // being consumed this cycle; it forwards from EX on the next cycle.
      assign hazard_src[gi] = use_src[gi] &&
        ((out_valid && wr_reg && (dst_reg == src[gi])) ||
         (bus.ex_ld_pend && (bus.ex_ld_addr == src[gi])));
    end
  endgenerate

  assign hazard   = bus.in_valid && (|hazard_src);
  assign in_ready = !hazard && !bus.flush && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = EMPTY;
    end else if (accept) begin
      state_next = FULL;
    end else if ((state_reg == FULL) && bus.out_ready) begin
      state_next = EMPTY;
    end
  end

  // Fields change only on accept, so a stalled or flushed entry never sees
  // later forwarding values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_reg     <= '0;
      op2_reg     <= '0;
      dst_reg     <= '0;
      wr_reg      <= 1'b0;
      is_load_reg <= 1'b0;
    end else if (accept) begin
      op1_reg     <= resolved[0];
      op2_reg     <= resolved[1];
      dst_reg     <= bus.in_dst;
      wr_reg      <= bus.in_wr;
      is_load_reg <= bus.in_is_load;
    end
  end

  always_comb begin
    stall_next = stall_reg;
    if (hazard && !bus.flush && (stall_reg != {STALL_BITS{1'b1}})) begin
      stall_next = stall_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_reg <= '0;
    end else begin
      stall_reg <= stall_next;
    end
  end

  assign bus.r_addr1     = bus.in_src1;
  assign bus.r_addr2     = bus.in_src2;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_op1     = op1_reg;
  assign bus.out_op2     = op2_reg;
  assign bus.out_dst     = dst_reg;
  assign bus.out_wr      = wr_reg;
  assign bus.out_is_load = is_load_reg;
  assign bus.stall_cnt   = stall_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed vector bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  operand_fetch_if #(.DATA_BITS(32), .ADDRESS_BITS(4), .STALL_BITS(16)) bus ();

  operand_fetch #(.DATA_BITS(32), .ADDRESS_BITS(4), .STALL_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rf [16];
  assign bus.d_out1 = rf[bus.r_addr1];
  assign bus.d_out2 = rf[bus.r_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  src1, src2;
    logic        use1, use2;
    logic [3:0]  dst;
    logic        wr, ld;
    logic        ordy, flush;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fx_en;
    logic [3:0]  fx_addr;
    logic [31:0] fx_data;
    logic        ld_pend;
    logic [3:0]  ld_addr;
    logic        e_ready, e_valid;
    logic [31:0] e_op1, e_op2;
    logic [3:0]  e_dst;
    logic        e_wr, e_ld;
    logic [15:0] e_stall;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    bus.in_valid    = v.valid;
    bus.in_src1     = v.src1;
    bus.in_src2     = v.src2;
    bus.in_use1     = v.use1;
    bus.in_use2     = v.use2;
    bus.in_dst      = v.dst;
    bus.in_wr       = v.wr;
    bus.in_is_load  = v.ld;
    bus.out_ready   = v.ordy;
    bus.flush       = v.flush;
    bus.wb_wrt_en   = v.wb_en;
    bus.wb_w_addr   = v.wb_addr;
    bus.wb_d_in     = v.wb_data;
    bus.ex_fwd_en   = v.fx_en;
    bus.ex_fwd_addr = v.fx_addr;
    bus.ex_fwd_data = v.fx_data;
    bus.ex_ld_pend  = v.ld_pend;
    bus.ex_ld_addr  = v.ld_addr;
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(v.e_ready));
    check({tag, ".r_addr1"},  32'(bus.r_addr1),  32'(v.src1));
    check({tag, ".r_addr2"},  32'(bus.r_addr2),  32'(v.src2));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.e_valid));
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(v.e_stall));
    if (v.e_valid) begin
      check({tag, ".out_op1"},     bus.out_op1,            v.e_op1);
      check({tag, ".out_op2"},     bus.out_op2,            v.e_op2);
      check({tag, ".out_dst"},     32'(bus.out_dst),       32'(v.e_dst));
      check({tag, ".out_wr"},      32'(bus.out_wr),        32'(v.e_wr));
      check({tag, ".out_is_load"}, 32'(bus.out_is_load),   32'(v.e_ld));
    end
    $display("%s: in_ready=%0b out_valid=%0b op1=0x%0h op2=0x%0h dst=%0d stall=%0d",
             tag, v.e_ready, bus.out_valid, bus.out_op1, bus.out_op2, bus.out_dst, bus.stall_cnt);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"},   32'(bus.out_valid),   32'd0);
    check({tag, ".out_op1"},     bus.out_op1,          32'd0);
    check({tag, ".out_op2"},     bus.out_op2,          32'd0);
    check({tag, ".out_dst"},     32'(bus.out_dst),     32'd0);
    check({tag, ".out_wr"},      32'(bus.out_wr),      32'd0);
    check({tag, ".out_is_load"}, 32'(bus.out_is_load), 32'd0);
    check({tag, ".stall_cnt"},   32'(bus.stall_cnt),   32'd0);
    $display("%s: out_valid=%0b stall=%0d", tag, bus.out_valid, bus.stall_cnt);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
    rf[3] = 32'h11;
    rf[4] = 32'h22;
    rf[7] = 32'h1234;

    // valid src1 src2 u1 u2 dst wr ld | ordy flush | wb | fx | ldp | e_ready e_valid op1 op2 dst wr ld stall
    tbl[0]  = '{1,3,4,1,1,5,1,0, 1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h11,  32'h22,  5,1,0,0};
    tbl[1]  = '{1,3,4,1,1,5,1,0, 1,0, 1,3,32'hAA,  0,0,0,          0,0, 1,1,32'hAA,  32'h22,  5,1,0,0};
    tbl[2]  = '{1,3,4,1,1,5,1,0, 1,0, 1,3,32'hAA,  1,3,32'hBB,     0,0, 1,1,32'hBB,  32'h22,  5,1,0,0};
    tbl[3]  = '{1,1,2,1,1,6,1,0, 1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h1001,32'h1002,6,1,0,0};
    tbl[4]  = '{1,6,2,1,1,8,1,0, 1,0, 0,0,0,       0,0,0,          0,0, 0,0,0,       0,       0,0,0,1};
    tbl[5]  = '{1,6,2,1,1,8,1,0, 1,0, 0,0,0,       1,6,32'hCAFE,   0,0, 1,1,32'hCAFE,32'h1002,8,1,0,1};
    tbl[6]  = '{1,8,2,0,1,9,0,0, 1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h1008,32'h1002,9,0,0,1};
    tbl[7]  = '{1,1,7,1,1,10,1,1,1,0, 0,0,0,       0,0,0,          1,7, 0,0,0,       0,       0,0,0,2};
    tbl[8]  = '{1,1,7,1,1,10,1,1,1,0, 0,0,0,       0,0,0,          1,7, 0,0,0,       0,       0,0,0,3};
    tbl[9]  = '{1,1,7,1,1,10,1,1,1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h1001,32'h1234,10,1,1,3};
    tbl[10] = '{1,1,2,1,1,11,0,0,0,0, 0,0,0,       0,0,0,          0,0, 0,1,32'h1001,32'h1234,10,1,1,3};
    tbl[11] = '{1,1,2,1,1,11,0,0,0,0, 1,2,32'hBEEF,1,1,32'hDEAD,   0,0, 0,1,32'h1001,32'h1234,10,1,1,3};
    tbl[12] = '{1,1,2,1,1,11,0,0,0,0, 0,0,0,       0,0,0,          0,0, 0,1,32'h1001,32'h1234,10,1,1,3};
    tbl[13] = '{1,1,2,1,1,11,0,0,1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h1001,32'h1002,11,0,0,3};
    tbl[14] = '{1,1,2,1,1,12,1,0,1,1, 0,0,0,       0,0,0,          0,0, 0,0,0,       0,       0,0,0,3};
    tbl[15] = '{1,1,2,1,1,12,1,0,1,1, 0,0,0,       0,0,0,          1,1, 0,0,0,       0,       0,0,0,3};
    tbl[16] = '{1,1,2,1,1,12,1,0,1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h1001,32'h1002,12,1,0,3};
    tbl[17] = '{0,0,0,0,0,0,0,0, 1,0, 0,0,0,       0,0,0,          0,0, 1,0,0,       0,       0,0,0,3};
    tbl[18] = '{1,3,4,1,1,5,0,1, 1,0, 0,0,0,       0,0,0,          0,0, 1,1,32'h11,  32'h22,  5,0,1,3};

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_src1     = '0;
    bus.in_src2     = '0;
    bus.in_use1     = 1'b0;
    bus.in_use2     = 1'b0;
    bus.in_dst      = '0;
    bus.in_wr       = 1'b0;
    bus.in_is_load  = 1'b0;
    bus.out_ready   = 1'b0;
    bus.flush       = 1'b0;
    bus.wb_wrt_en   = 1'b0;
    bus.wb_w_addr   = '0;
    bus.wb_d_in     = '0;
    bus.ex_fwd_en   = 1'b0;
    bus.ex_fwd_addr = '0;
    bus.ex_fwd_data = '0;
    bus.ex_ld_pend  = 1'b0;
    bus.ex_ld_addr  = '0;
    #1;
    check_reset_state("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset with a full entry and a nonzero stall count.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(tbl[0], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
